grf_wb_sink: RTL
================

Name: grf_wb_sink

Overview:
- Receiving end of the writeback interface: consumes the W-stage write request (write enable, register address, write data, retiring PC).
- Holds the 32x32 general register file and serves the two D-stage read ports.
- Keeps a buffered commit log of every architectural register write, drained through a valid/ready handshake by the debug/trace consumer.
- Sits between the W pipeline register and the D stage.

Parameters:
- LOG_DEPTH, 4, commit-log FIFO entries; power of two, minimum 2.
- PC_RESET, 32'h00003000, informational base PC; not used in datapath logic and not checked against.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous reset, active high.
- we  input  1  writeback enable from W stage.
- wa  input  5  writeback register address.
- wd  input  32  writeback data.
- wpc  input  32  PC of the retiring instruction.
- ra1  input  5  read address, port 1.
- ra2  input  5  read address, port 2.
- rd1  output  32  read data, port 1.
- rd2  output  32  read data, port 2.
- log_valid  output  1  commit-log head entry valid.
- log_ready  input  1  consumer accepts the head entry.
- log_pc  output  32  head entry PC.
- log_addr  output  5  head entry register address.
- log_data  output  32  head entry data.
- log_count  output  $clog2(LOG_DEPTH)+1  FIFO occupancy.
- log_overflow  output  1  sticky: an entry was dropped.
- commit_cnt  output  32  number of committed architectural writes.

Behaviour:
- Reset is synchronous, active-high; clock clk.
  - On reset: all 32 registers = 0, FIFO empty, log_count = 0, log_valid = 0, log_overflow = 0, commit_cnt = 0.
  - Reset overrides any concurrent write or pop.
- Architectural write:
  - Condition: we=1 and wa!=0.
  - Regfile[wa] <= wd at the posedge; commit_cnt increments by 1 (wraps at 2^32).
  - we=1 with wa=0: no regfile change, no count, no log entry.
- Register $0 always reads 0.
- Read ports are combinational from the array (zero-cycle latency).
  - Forwarding depends on WB_BYPASS_EN (see Optional Feature).
- Commit log push:
  - Every architectural write pushes the entry {wpc, wa, wd}.
  - Push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - If the FIFO is full and no pop: the entry is dropped, log_overflow <= 1 (sticky until reset).
  - A dropped entry still updates the regfile and commit_cnt.
- Commit log pop:
  - Pop occurs when log_valid=1 and log_ready=1 at the posedge.
  - log_valid = (log_count != 0).
  - log_pc/log_addr/log_data present the head entry and hold stable while log_valid=1 and log_ready=0.
  - When empty, the log outputs are don't-care; the bench must not check them.
- Simultaneous push and pop:
  - Empty: no pop is possible; the push lands and log_valid rises next cycle. No empty-FIFO fall-through: first visibility is one cycle after the write.
  - Full: both are performed and log_count is unchanged.
- Pointers are $clog2(LOG_DEPTH) bits and wrap naturally.
- log_count is registered and updates at the same edge as push/pop.
- Entries leave in strict push order.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: if we=1, wa!=0 and wa==raN, then rdN = wd in the same cycle (write-through forwarding from W to D).
- Undefined: rdN always returns the stored array value, so a write becomes visible on the cycle after its posedge. The hazard unit must then cover the W-to-D distance.

Test Plan:
- Reset, then ra1=5, ra2=0 -> rd1=0, rd2=0, log_valid=0, log_count=0, commit_cnt=0.
- we=1, wa=5, wd=32'h1234_5678, wpc=32'h3000; next cycle ra1=5 -> rd1=32'h12345678, log_valid=1, log_pc=32'h3000, log_addr=5, log_data=32'h12345678, commit_cnt=1.
- we=1, wa=0, wd=32'hFFFF_FFFF; ra1=0 -> rd1=0 always, log_count unchanged, commit_cnt unchanged.
- Same-cycle read of the register being written, with wa=ra1=7 and wd=32'hA5A5:
  - WB_BYPASS_EN defined: rd1=32'hA5A5 that cycle.
  - Undefined: rd1 = old value that cycle, 32'hA5A5 next cycle.
- log_ready=0, five writes to regs 1..5 with data 1..5 (LOG_DEPTH=4):
  - log_count saturates at 4 and log_overflow=1.
  - Draining yields addr 1,2,3,4 in order; reg 5 still reads 5; commit_cnt=5.
- FIFO full with log_ready=1 and a write to reg 9 in the same cycle -> log_count stays 4, no overflow, the reg-9 entry appears last in the drain. Then reset asserted mid-drain -> log_valid=0 and log_overflow=0 the next cycle.

Source files
------------

// File: rtl/grf_wb_sink.sv
// grf_wb_sink: writeback sink holding the 32x32 register file, D-stage read ports and a commit-log FIFO.
// Define WB_BYPASS_EN to forward the W-stage write data straight to the read ports in the same cycle.
module grf_wb_sink #(
    parameter int          LOG_DEPTH = 4,
    parameter logic [31:0] PC_RESET  = 32'h00003000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [4:0]                   wa,
    input  logic [31:0]                  wd,
    input  logic [31:0]                  wpc,
    input  logic [4:0]                   ra1,
    input  logic [4:0]                   ra2,
    output logic [31:0]                  rd1,
    output logic [31:0]                  rd2,
    output logic                         log_valid,
    input  logic                         log_ready,
    output logic [31:0]                  log_pc,
    output logic [4:0]                   log_addr,
    output logic [31:0]                  log_data,
    output logic [$clog2(LOG_DEPTH):0]   log_count,
    output logic                         log_overflow,
    output logic [31:0]                  commit_cnt
);
    localparam int          AW     = $clog2(LOG_DEPTH);
    localparam logic [AW:0] L_FULL = (AW + 1)'(LOG_DEPTH);

    logic [31:0]   r_regs [32];
    logic [68:0]   r_fifo [LOG_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic [31:0]   r_commit_cnt;
    logic          w_commit;
    logic          w_pop;
    logic          w_full;
    logic          w_push;

    always_comb begin
        w_commit = we && (wa != 5'd0);
        w_pop    = (r_count != '0) && log_ready;
        w_full   = (r_count == L_FULL);
        w_push   = w_commit && (!w_full || w_pop);
    end

    always_comb begin
        rd1 = (ra1 == 5'd0) ? 32'd0 : r_regs[ra1];
        rd2 = (ra2 == 5'd0) ? 32'd0 : r_regs[ra2];
`ifdef WB_BYPASS_EN
        rd1 = (w_commit && wa == ra1) ? wd : rd1;
        rd2 = (w_commit && wa == ra2) ? wd : rd2;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
            r_commit_cnt <= '0;
        end else if (w_commit) begin
            r_regs[wa]   <= wd;
            r_commit_cnt <= r_commit_cnt + 1'b1;
        end
    end

    // Log storage needs no reset: entries are only observable while counted.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= {wpc, wa, wd};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
            r_rd_ptr   <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
            r_count    <= (w_push && !w_pop) ? r_count + 1'b1 :
                          (!w_push && w_pop) ? r_count - 1'b1 : r_count;
            r_overflow <= r_overflow || (w_commit && !w_push);
        end
    end

    assign {log_pc, log_addr, log_data} = r_fifo[r_rd_ptr];
    assign log_valid    = (r_count != '0);
    assign log_count    = r_count;
    assign log_overflow = r_overflow;
    assign commit_cnt   = r_commit_cnt;
endmodule
